// File: rtl/hdv_activity_profiler.sv
// ---------------------------------------------------------------------------
// hdv_activity_profiler
// On-chip profiler for ap_ctrl_hs handshakes. Each monitored channel runs a
// small FSM that measures start-to-ready and start-to-done cycle counts for
// every invocation. Completed invocations are parked in a one-entry pending
// slot per channel, and a fixed-priority arbiter moves them into a shared
// show-ahead record FIFO that the host drains over a valid/ready port.
//
// Ports:
//   ap_clk, ap_rst_n      clock, asynchronous active-low reset
//   enable                arm capture of new invocations
//   clear                 synchronous clear of all state
//   mon_start/ready/done  per-channel ap_start / ap_ready / ap_done
//   rec_valid/rec_ready   record port handshake
//   rec_id                channel index of the head record
//   rec_rdy_cyc           start-to-first-ready cycles (inclusive)
//   rec_lat_cyc           start-to-done cycles (inclusive)
//   drop_cnt              saturating count of records lost to back-pressure
//   busy                  per-channel ACTIVE indication
// ---------------------------------------------------------------------------
module hdv_activity_profiler #(
    parameter int unsigned NUM_MON    = 5,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               enable,
    input  logic               clear,
    input  logic [NUM_MON-1:0] mon_start,
    input  logic [NUM_MON-1:0] mon_ready,
    input  logic [NUM_MON-1:0] mon_done,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [2:0]         rec_id,
    output logic [CNT_W-1:0]   rec_rdy_cyc,
    output logic [CNT_W-1:0]   rec_lat_cyc,
    output logic [15:0]        drop_cnt,
    output logic [NUM_MON-1:0] busy
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_FW = PTR_W + 1;
    localparam int unsigned ID_W   = 3;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

    // ---------------- channel FSM state ----------------
    state_e           state_q   [NUM_MON];
    state_e           state_d   [NUM_MON];
    logic [CNT_W-1:0] lat_q     [NUM_MON];
    logic [CNT_W-1:0] lat_d     [NUM_MON];
    logic [CNT_W-1:0] rdy_q     [NUM_MON];   // 0 means ready not yet seen
    logic [CNT_W-1:0] rdy_d     [NUM_MON];
    logic [CNT_W-1:0] lat_inc_c [NUM_MON];

    logic [NUM_MON-1:0] emit_c;
    logic [CNT_W-1:0]   emit_rdy_c [NUM_MON];
    logic [CNT_W-1:0]   emit_lat_c [NUM_MON];

    // ---------------- pending slots / drop counter ----------------
    logic [NUM_MON-1:0] pend_full_q;
    logic [NUM_MON-1:0] pend_full_d;
    logic [CNT_W-1:0]   pend_rdy_q [NUM_MON];
    logic [CNT_W-1:0]   pend_rdy_d [NUM_MON];
    logic [CNT_W-1:0]   pend_lat_q [NUM_MON];
    logic [CNT_W-1:0]   pend_lat_d [NUM_MON];
    logic [15:0]        drop_cnt_q;
    logic [15:0]        drop_cnt_d;
    logic [3:0]         drop_n_c;
    logic [16:0]        drop_sum_c;

    // ---------------- arbiter ----------------
    logic               arb_valid_c;
    logic [ID_W-1:0]    arb_sel_c;
    logic [CNT_W-1:0]   push_rdy_c;
    logic [CNT_W-1:0]   push_lat_c;
    logic [NUM_MON-1:0] drain_c;

    // ---------------- FIFO ----------------
    logic [ID_W-1:0]   mem_id  [FIFO_DEPTH];
    logic [CNT_W-1:0]  mem_rdy [FIFO_DEPTH];
    logic [CNT_W-1:0]  mem_lat [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_FW-1:0] fifo_cnt_q;
    logic              fifo_full_c;
    logic              push_c;
    logic              pop_c;
    logic [PTR_W-1:0]  rd_nxt_c;
    logic [CNT_FW-1:0] cnt_after_pop_c;
    logic              head_valid_nxt_c;

    logic              rec_valid_q;
    logic [ID_W-1:0]   rec_id_q;
    logic [CNT_W-1:0]  rec_rdy_q;
    logic [CNT_W-1:0]  rec_lat_q;

    // Saturating increment of each channel's latency counter.
    always_comb begin
        for (int unsigned i = 0; i < NUM_MON; i++) begin
            lat_inc_c[i] = (&lat_q[i]) ? lat_q[i] : lat_q[i] + CNT_W'(1);
        end
    end

    // Channel FSM next-state and record emission.
    always_comb begin
        for (int unsigned i = 0; i < NUM_MON; i++) begin
            state_d[i]    = state_q[i];
            lat_d[i]      = lat_q[i];
            rdy_d[i]      = rdy_q[i];
            emit_c[i]     = 1'b0;
            emit_rdy_c[i] = '0;
            emit_lat_c[i] = '0;

            if (state_q[i] == S_IDLE) begin
                if (mon_start[i] && enable) begin
                    if (mon_done[i]) begin
                        // Whole invocation completes in the start cycle.
                        emit_c[i]     = 1'b1;
                        emit_rdy_c[i] = CNT_W'(1);
                        emit_lat_c[i] = CNT_W'(1);
                    end else begin
                        state_d[i] = S_ACTIVE;
                        lat_d[i]   = CNT_W'(1);
                        rdy_d[i]   = mon_ready[i] ? CNT_W'(1) : '0;
                    end
                end
            end else begin
                if (mon_done[i]) begin
                    emit_c[i]     = 1'b1;
                    emit_lat_c[i] = lat_inc_c[i];
                    emit_rdy_c[i] = (rdy_q[i] != '0) ? rdy_q[i] : lat_inc_c[i];
                    if (mon_start[i] && enable) begin
                        // Back-to-back invocation starts in the done cycle.
                        lat_d[i] = CNT_W'(1);
                        rdy_d[i] = mon_ready[i] ? CNT_W'(1) : '0;
                    end else begin
                        state_d[i] = S_IDLE;
                        lat_d[i]   = '0;
                        rdy_d[i]   = '0;
                    end
                end else begin
                    lat_d[i] = lat_inc_c[i];
                    if ((rdy_q[i] == '0) && mon_ready[i]) begin
                        rdy_d[i] = lat_inc_c[i];
                    end
                end
            end
        end
    end

    // Channel FSM registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int unsigned i = 0; i < NUM_MON; i++) begin
                state_q[i] <= S_IDLE;
                lat_q[i]   <= '0;
                rdy_q[i]   <= '0;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < NUM_MON; i++) begin
                state_q[i] <= S_IDLE;
                lat_q[i]   <= '0;
                rdy_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_MON; i++) begin
                state_q[i] <= state_d[i];
                lat_q[i]   <= lat_d[i];
                rdy_q[i]   <= rdy_d[i];
            end
        end
    end

    // Fixed-priority arbiter: lowest-index full slot wins the FIFO write.
    always_comb begin
        arb_valid_c = 1'b0;
        arb_sel_c   = '0;
        push_rdy_c  = '0;
        push_lat_c  = '0;
        for (int unsigned i = 0; i < NUM_MON; i++) begin
            if (pend_full_q[i] && !arb_valid_c) begin
                arb_valid_c = 1'b1;
                arb_sel_c   = ID_W'(i);
                push_rdy_c  = pend_rdy_q[i];
                push_lat_c  = pend_lat_q[i];
            end
        end
    end

    // A full FIFO still accepts a write when the head is popped that cycle.
    assign pop_c       = rec_valid_q && rec_ready;
    assign fifo_full_c = (fifo_cnt_q == CNT_FW'(FIFO_DEPTH));
    assign push_c      = arb_valid_c && (!fifo_full_c || pop_c);

    // Pending-slot update; a slot draining this cycle may be refilled.
    always_comb begin
        pend_full_d = pend_full_q;
        drain_c     = '0;
        drop_n_c    = '0;
        for (int unsigned i = 0; i < NUM_MON; i++) begin
            pend_rdy_d[i] = pend_rdy_q[i];
            pend_lat_d[i] = pend_lat_q[i];
            drain_c[i]    = push_c && (arb_sel_c == ID_W'(i));
            if (emit_c[i]) begin
                if (pend_full_q[i] && !drain_c[i]) begin
                    drop_n_c = drop_n_c + 4'd1;
                end else begin
                    pend_full_d[i] = 1'b1;
                    pend_rdy_d[i]  = emit_rdy_c[i];
                    pend_lat_d[i]  = emit_lat_c[i];
                end
            end else if (drain_c[i]) begin
                pend_full_d[i] = 1'b0;
            end
        end
        drop_sum_c = {1'b0, drop_cnt_q} + 17'(drop_n_c);
        drop_cnt_d = drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
    end

    // Pending slots and drop counter.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pend_full_q <= '0;
            drop_cnt_q  <= '0;
            for (int unsigned i = 0; i < NUM_MON; i++) begin
                pend_rdy_q[i] <= '0;
                pend_lat_q[i] <= '0;
            end
        end else if (clear) begin
            pend_full_q <= '0;
            drop_cnt_q  <= '0;
            for (int unsigned i = 0; i < NUM_MON; i++) begin
                pend_rdy_q[i] <= '0;
                pend_lat_q[i] <= '0;
            end
        end else begin
            pend_full_q <= pend_full_d;
            drop_cnt_q  <= drop_cnt_d;
            for (int unsigned i = 0; i < NUM_MON; i++) begin
                pend_rdy_q[i] <= pend_rdy_d[i];
                pend_lat_q[i] <= pend_lat_d[i];
            end
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge ap_clk) begin
        if (push_c) begin
            mem_id[wr_ptr_q]  <= arb_sel_c;
            mem_rdy[wr_ptr_q] <= push_rdy_c;
            mem_lat[wr_ptr_q] <= push_lat_c;
        end
    end

    // Output register mirrors the head after this cycle's pop; a write
    // becomes visible at the head one cycle after it lands in storage.
    assign rd_nxt_c         = rd_ptr_q + PTR_W'(pop_c);
    assign cnt_after_pop_c  = fifo_cnt_q - CNT_FW'(pop_c);
    assign head_valid_nxt_c = (cnt_after_pop_c != '0);

    // FIFO pointers, occupancy and registered head.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            rec_valid_q <= 1'b0;
            rec_id_q    <= '0;
            rec_rdy_q   <= '0;
            rec_lat_q   <= '0;
        end else if (clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            rec_valid_q <= 1'b0;
            rec_id_q    <= '0;
            rec_rdy_q   <= '0;
            rec_lat_q   <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q <= rd_nxt_c;
            case ({push_c, pop_c})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_FW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_FW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            rec_valid_q <= head_valid_nxt_c;
            if (head_valid_nxt_c) begin
                rec_id_q  <= mem_id[rd_nxt_c];
                rec_rdy_q <= mem_rdy[rd_nxt_c];
                rec_lat_q <= mem_lat[rd_nxt_c];
            end
        end
    end

    // Busy is a direct decode of the state registers.
    always_comb begin
        for (int unsigned i = 0; i < NUM_MON; i++) begin
            busy[i] = (state_q[i] == S_ACTIVE);
        end
    end

    assign rec_valid   = rec_valid_q;
    assign rec_id      = rec_id_q;
    assign rec_rdy_cyc = rec_rdy_q;
    assign rec_lat_cyc = rec_lat_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_hdv_activity_profiler.sv
// ---------------------------------------------------------------------------
// tb_hdv_activity_profiler
// Scenario tasks drive handshakes and push expected records into a queue;
// a monitor pops and compares every record the profiler hands out.
// ---------------------------------------------------------------------------
module tb_hdv_activity_profiler;

    localparam int unsigned NUM_MON    = 5;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned FIFO_DEPTH = 16;

    typedef struct packed {
        logic [2:0]       id;
        logic [CNT_W-1:0] rdy;
        logic [CNT_W-1:0] lat;
    } rec_t;

    logic               ap_clk;
    logic               ap_rst_n;
    logic               enable;
    logic               clear;
    logic [NUM_MON-1:0] mon_start;
    logic [NUM_MON-1:0] mon_ready;
    logic [NUM_MON-1:0] mon_done;
    logic               rec_valid;
    logic               rec_ready;
    logic [2:0]         rec_id;
    logic [CNT_W-1:0]   rec_rdy_cyc;
    logic [CNT_W-1:0]   rec_lat_cyc;
    logic [15:0]        drop_cnt;
    logic [NUM_MON-1:0] busy;

    int   checks;
    int   errors;
    int   rx_count;
    rec_t exp_q[$];

    hdv_activity_profiler #(
        .NUM_MON   (NUM_MON),
        .CNT_W     (CNT_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .enable     (enable),
        .clear      (clear),
        .mon_start  (mon_start),
        .mon_ready  (mon_ready),
        .mon_done   (mon_done),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_id     (rec_id),
        .rec_rdy_cyc(rec_rdy_cyc),
        .rec_lat_cyc(rec_lat_cyc),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Handshake completes at the next rising edge; compare against the queue.
    always @(negedge ap_clk) begin
        if (ap_rst_n && rec_valid && rec_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record: got id=%0d rdy=%0d lat=%0d, expected none",
                         rec_id, rec_rdy_cyc, rec_lat_cyc);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                if ({rec_id, rec_rdy_cyc, rec_lat_cyc} !== {e.id, e.rdy, e.lat}) begin
                    errors++;
                    $display("FAIL record: got id=%0d rdy=%0d lat=%0d, expected id=%0d rdy=%0d lat=%0d",
                             rec_id, rec_rdy_cyc, rec_lat_cyc, e.id, e.rdy, e.lat);
                end
            end
            rx_count++;
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle_inputs();
        mon_start = '0;
        mon_ready = '0;
        mon_done  = '0;
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int k = 0; k < max_cyc && exp_q.size() != 0; k++) tick();
    endtask

    task automatic test_reset();
        ap_rst_n  = 1'b0;
        enable    = 1'b1;
        clear     = 1'b0;
        rec_ready = 1'b0;
        idle_inputs();
        repeat (3) tick();
        checks++;
        if ({rec_valid, rec_id, rec_rdy_cyc, rec_lat_cyc, drop_cnt, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b id=%0d rdy=%0d lat=%0d drop=%0d busy=%b, expected all 0",
                     rec_valid, rec_id, rec_rdy_cyc, rec_lat_cyc, drop_cnt, busy);
        end
        ap_rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if ({rec_valid, drop_cnt, busy} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got valid=%0b drop=%0d busy=%b, expected 0",
                     rec_valid, drop_cnt, busy);
        end
    endtask

    task automatic test_single();
        exp_q.push_back('{id: 3'd2, rdy: 32'd3, lat: 32'd8});
        rec_ready = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            mon_start = (k == 0) ? 5'b00100 : 5'b00000;
            mon_ready = (k == 2) ? 5'b00100 : 5'b00000;
            mon_done  = (k == 7) ? 5'b00100 : 5'b00000;
            tick();
            if (k <= 6) begin
                checks++;
                if (busy !== 5'b00100) begin
                    errors++;
                    $display("FAIL single_busy_k%0d: got %b, expected 00100", k, busy);
                end
            end else if (k == 7) begin
                checks++;
                if (busy !== 5'b00000) begin
                    errors++;
                    $display("FAIL single_busy_after_done: got %b, expected 00000", busy);
                end
            end else if (k == 8) begin
                checks++;
                if (rec_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL single_valid_early: got %0b, expected 0", rec_valid);
                end
            end else begin
                checks++;
                if (rec_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL single_valid_latency: got %0b, expected 1", rec_valid);
                end
            end
            idle_inputs();
        end
        wait_drain(50);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_comb();
        exp_q.push_back('{id: 3'd0, rdy: 32'd1, lat: 32'd1});
        mon_start = 5'b00001;
        mon_ready = 5'b00001;
        mon_done  = 5'b00001;
        tick();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy !== 5'b00000) begin
                errors++;
                $display("FAIL comb_busy_k%0d: got %b, expected 00000", k, busy);
            end
            tick();
        end
        wait_drain(50);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL comb_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back('{id: 3'd1, rdy: 32'd2, lat: 32'd5});
        exp_q.push_back('{id: 3'd1, rdy: 32'd5, lat: 32'd5});
        for (int k = 0; k <= 8; k++) begin
            mon_start = (k == 0 || k == 4) ? 5'b00010 : 5'b00000;
            mon_ready = (k == 1) ? 5'b00010 : 5'b00000;
            mon_done  = (k == 4 || k == 8) ? 5'b00010 : 5'b00000;
            tick();
            checks++;
            if (busy !== ((k < 8) ? 5'b00010 : 5'b00000)) begin
                errors++;
                $display("FAIL b2b_busy_k%0d: got %b, expected %b", k, busy,
                         (k < 8) ? 5'b00010 : 5'b00000);
            end
        end
        idle_inputs();
        wait_drain(50);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        exp_q.push_back('{id: 3'd0, rdy: 32'd2, lat: 32'd2});
        exp_q.push_back('{id: 3'd3, rdy: 32'd3, lat: 32'd3});
        exp_q.push_back('{id: 3'd4, rdy: 32'd2, lat: 32'd4});
        for (int k = 0; k <= 3; k++) begin
            mon_start = ((k == 0) ? 5'b10000 : 5'b00000) |
                        ((k == 1) ? 5'b01000 : 5'b00000) |
                        ((k == 2) ? 5'b00001 : 5'b00000);
            mon_ready = (k == 1) ? 5'b10000 : 5'b00000;
            mon_done  = (k == 3) ? 5'b11001 : 5'b00000;
            tick();
        end
        idle_inputs();
        wait_drain(50);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL simul_drain: got %0d pending, expected 0", exp_q.size());
        end
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL simul_drop: got %0d, expected 0", drop_cnt);
        end
    endtask

    task automatic test_backpressure();
        int rx_before;
        rec_ready = 1'b0;
        for (int j = 0; j < 17; j++) exp_q.push_back('{id: 3'd0, rdy: 32'd4, lat: 32'd4});
        for (int k = 0; k <= 54; k++) begin
            mon_start = ((k % 3) == 0 && k <= 51) ? 5'b00001 : 5'b00000;
            mon_done  = ((k % 3) == 0 && k >= 3) ? 5'b00001 : 5'b00000;
            tick();
        end
        idle_inputs();
        repeat (4) tick();
        checks++;
        if (drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bp_drop: got %0d, expected 1", drop_cnt);
        end
        checks++;
        if (rec_valid !== 1'b1 || busy !== 5'b00000) begin
            errors++;
            $display("FAIL bp_hold: got valid=%0b busy=%b, expected valid=1 busy=00000", rec_valid, busy);
        end
        rx_before = rx_count;
        rec_ready = 1'b1;
        wait_drain(200);
        repeat (4) tick();
        checks++;
        if (rx_count - rx_before != 17 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d records, expected 17", rx_count - rx_before);
        end
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got valid=%0b, expected 0", rec_valid);
        end
    endtask

    task automatic test_async_reset();
        int rx_before;
        rec_ready = 1'b0;
        mon_start = 5'b00011;
        mon_ready = 5'b00001;
        mon_done  = 5'b00001;
        tick();
        idle_inputs();
        repeat (4) tick();
        checks++;
        if (rec_valid !== 1'b1 || busy !== 5'b00010 || drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rst_precond: got valid=%0b busy=%b drop=%0d, expected 1 00010 1",
                     rec_valid, busy, drop_cnt);
        end
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (rec_valid !== 1'b0 || drop_cnt !== 16'd0 || busy !== 5'b00000) begin
            errors++;
            $display("FAIL rst_async: got valid=%0b drop=%0d busy=%b, expected 0 0 00000",
                     rec_valid, drop_cnt, busy);
        end
        tick();
        ap_rst_n = 1'b1;
        tick();
        rx_before = rx_count;
        rec_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (rec_valid !== 1'b0 || rx_count != rx_before) begin
            errors++;
            $display("FAIL rst_discard: got valid=%0b records=%0d, expected 0 0",
                     rec_valid, rx_count - rx_before);
        end
    endtask

    task automatic test_enable();
        int rx_before;
        rx_before = rx_count;
        rec_ready = 1'b1;
        exp_q.push_back('{id: 3'd1, rdy: 32'd5, lat: 32'd5});
        for (int k = 0; k <= 4; k++) begin
            enable    = (k == 0);
            mon_start = (k == 0) ? 5'b00010 : 5'b00000;
            mon_done  = (k == 4) ? 5'b00010 : 5'b00000;
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            mon_start = 5'b00010;
            tick();
            checks++;
            if (busy !== 5'b00000) begin
                errors++;
                $display("FAIL enable_ignore_k%0d: got busy=%b, expected 00000", k, busy);
            end
        end
        idle_inputs();
        enable = 1'b1;
        wait_drain(50);
        repeat (6) tick();
        checks++;
        if (rx_count - rx_before != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL enable_records: got %0d records, expected 1", rx_count - rx_before);
        end
    endtask

    task automatic test_clear();
        int rx_before;
        rec_ready = 1'b0;
        mon_start = 5'b01001;
        mon_done  = 5'b00001;
        tick();
        idle_inputs();
        repeat (4) tick();
        checks++;
        if (rec_valid !== 1'b1 || busy !== 5'b01000 || rec_lat_cyc !== 32'd1) begin
            errors++;
            $display("FAIL clear_precond: got valid=%0b busy=%b lat=%0d, expected 1 01000 1",
                     rec_valid, busy, rec_lat_cyc);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if ({rec_valid, rec_id, rec_rdy_cyc, rec_lat_cyc, drop_cnt, busy} !== '0) begin
            errors++;
            $display("FAIL clear_outputs: got valid=%0b id=%0d rdy=%0d lat=%0d drop=%0d busy=%b, expected all 0",
                     rec_valid, rec_id, rec_rdy_cyc, rec_lat_cyc, drop_cnt, busy);
        end
        rx_before = rx_count;
        rec_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (rec_valid !== 1'b0 || rx_count != rx_before) begin
            errors++;
            $display("FAIL clear_discard: got valid=%0b records=%0d, expected 0 0",
                     rec_valid, rx_count - rx_before);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rx_count = 0;
        test_reset();
        test_single();
        test_comb();
        test_back_to_back();
        test_simultaneous();
        test_backpressure();
        test_async_reset();
        test_enable();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
